// File: rtl/fp_to_int_seq.sv
// Sequential FP {sign, exp, mant} to signed integer converter, round toward zero.
// The alignment shift runs one bit per cycle; results are held until out_ready.
module fp_to_int_seq #(
    parameter int NX = 8,
    parameter int NM = 23,
    parameter int NI = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NX+NM:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NI-1:0]    out_data,
    output logic             out_invalid,
    output logic             out_inexact
);

    localparam int XOFF = 2**(NX-1) - 1;
    localparam int ACCW = (NI > NM + 1) ? NI : NM + 1;
    localparam int MAXC = (NM > NI - 2 - NM) ? NM : NI - 2 - NM;
    localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);

    // Biased-exponent thresholds, so the unbiased exponent never has to be signed
    localparam logic [31:0] E_BIAS = 32'(XOFF);
    localparam logic [31:0] E_NM   = 32'(XOFF + NM);
    localparam logic [31:0] E_TOP  = 32'(XOFF + NI - 1);

    localparam logic [NX-1:0] EXP_ONES = '1;
    localparam logic [NI-1:0] INT_MIN  = {1'b1, {(NI-1){1'b0}}};
    localparam logic [NI-1:0] INT_MAX  = {1'b0, {(NI-1){1'b1}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]      state_reg;
    logic [ACCW-1:0] acc_reg;
    logic [CW-1:0]   cnt_reg;
    logic            sticky_reg;
    logic            sign_reg;
    logic            dir_left_reg;
    logic [NI-1:0]   out_data_reg;
    logic            out_invalid_reg;
    logic            out_inexact_reg;

    logic            sign_in;
    logic [NX-1:0]   exp_in;
    logic [NM-1:0]   mant_in;
    logic [31:0]     exp_u;
    logic            spec_hit;
    logic [NI-1:0]   spec_data;
    logic            spec_inv;
    logic            spec_inx;
    logic            norm_left;
    logic [CW-1:0]   norm_cnt;
    logic [ACCW-1:0] norm_acc;
    logic [ACCW-1:0] acc_shift;
    logic            sticky_shift;

    function automatic logic [NI-1:0] to_int(input logic [ACCW-1:0] a, input logic s);
        logic [NI-1:0] m;
        m = a[NI-1:0];
        return s ? (~m + 1'b1) : m;
    endfunction

    assign sign_in = in_data[NX+NM];
    assign exp_in  = in_data[NX+NM-1:NM];
    assign mant_in = in_data[NM-1:0];
    assign exp_u   = 32'(exp_in);

    // Operand classification; only the last branch needs the iterative shifter
    always_comb begin
        spec_hit  = 1'b1;
        spec_data = '0;
        spec_inv  = 1'b0;
        spec_inx  = 1'b0;
        norm_left = 1'b0;
        norm_cnt  = '0;
        norm_acc  = ACCW'({1'b1, mant_in});
        if (exp_in == EXP_ONES) begin
            spec_inv  = 1'b1;
            spec_data = ((mant_in != '0) || sign_in) ? INT_MIN : INT_MAX;
        end else if (exp_in == '0) begin
            spec_inx = (mant_in != '0);
        end else if (exp_u < E_BIAS) begin
            spec_inx = 1'b1;
        end else if (sign_in && (exp_u == E_TOP) && (mant_in == '0)) begin
            spec_data = INT_MIN;
        end else if (exp_u >= E_TOP) begin
            spec_inv  = 1'b1;
            spec_data = sign_in ? INT_MIN : INT_MAX;
        end else begin
            spec_hit = 1'b0;
            if (exp_u < E_NM) begin
                norm_left = 1'b0;
                norm_cnt  = CW'(E_NM - exp_u);
            end else begin
                norm_left = 1'b1;
                norm_cnt  = CW'(exp_u - E_NM);
            end
        end
    end

    always_comb begin
        acc_shift    = dir_left_reg ? (acc_reg << 1) : (acc_reg >> 1);
        sticky_shift = sticky_reg | (!dir_left_reg & acc_reg[0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            acc_reg         <= '0;
            cnt_reg         <= '0;
            sticky_reg      <= 1'b0;
            sign_reg        <= 1'b0;
            dir_left_reg    <= 1'b0;
            out_data_reg    <= '0;
            out_invalid_reg <= 1'b0;
            out_inexact_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        if (spec_hit) begin
                            out_data_reg    <= spec_data;
                            out_invalid_reg <= spec_inv;
                            out_inexact_reg <= spec_inx;
                            state_reg       <= S_DONE;
                        end else begin
                            acc_reg      <= norm_acc;
                            sticky_reg   <= 1'b0;
                            sign_reg     <= sign_in;
                            dir_left_reg <= norm_left;
                            cnt_reg      <= norm_cnt;
                            if (norm_cnt == '0) begin
                                out_data_reg    <= to_int(norm_acc, sign_in);
                                out_invalid_reg <= 1'b0;
                                out_inexact_reg <= 1'b0;
                                state_reg       <= S_DONE;
                            end else begin
                                state_reg <= S_SHIFT;
                            end
                        end
                    end
                end
                S_SHIFT: begin
                    acc_reg    <= acc_shift;
                    sticky_reg <= sticky_shift;
                    cnt_reg    <= cnt_reg - 1'b1;
                    if (cnt_reg == CW'(1)) begin
                        out_data_reg    <= to_int(acc_shift, sign_reg);
                        out_invalid_reg <= 1'b0;
                        out_inexact_reg <= sticky_shift;
                        state_reg       <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready    = (state_reg == S_IDLE) && !rst;
    assign out_valid   = (state_reg == S_DONE);
    assign out_data    = out_data_reg;
    assign out_invalid = out_invalid_reg;
    assign out_inexact = out_inexact_reg;

endmodule

// File: tb/tb_fp_to_int_seq.sv
// Randomized and directed bench for fp_to_int_seq (NX=8, NM=23, NI=32) against
// an arithmetic reference model of single-precision truncation to int32.
module tb_fp_to_int_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_invalid;
    logic        out_inexact;

    int n_vec = 0;
    int n_err = 0;

    fp_to_int_seq #(.NX(8), .NM(23), .NI(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_invalid(out_invalid),
        .out_inexact(out_inexact)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Truncation of value (1.mant)*2^e toward zero, with the saturation rules
    task automatic model(input logic [31:0] x, output logic [31:0] d, output logic inv,
                         output logic inx, output int lat);
        logic        s;
        int          ex;
        int          e;
        longint      sig;
        longint      mag;
        logic [63:0] v;
        s   = x[31];
        ex  = int'(x[30:23]);
        e   = ex - 127;
        sig = longint'({1'b1, x[22:0]});
        d   = '0;
        inv = 1'b0;
        inx = 1'b0;
        lat = 1;
        if (ex == 255) begin
            inv = 1'b1;
            d   = (x[22:0] != 0 || s) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end else if (ex == 0) begin
            inx = (x[22:0] != 0);
        end else if (e < 0) begin
            inx = 1'b1;
        end else if (e >= 31) begin
            if (s && e == 31 && x[22:0] == 0) begin
                d = 32'h8000_0000;
            end else begin
                inv = 1'b1;
                d   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            if (e >= 23) begin
                mag = sig << (e - 23);
                lat = 1 + (e - 23);
            end else begin
                mag = sig >> (23 - e);
                inx = ((sig & ((64'sd1 <<< (23 - e)) - 1)) != 0);
                lat = 1 + (23 - e);
            end
            v = s ? 64'(-mag) : 64'(mag);
            d = v[31:0];
        end
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge
    task automatic send(input logic [31:0] x);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_data  = x;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("accept_timeout", 32'(guard < 200), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic collect(input logic [31:0] x, input int hold, input bit early,
                           input logic [31:0] next_x);
        logic [31:0] ed;
        logic        einv;
        logic        einx;
        int          elat;
        int          k;
        logic        busy_ready;
        logic        stable;
        logic [31:0] d0;
        model(x, ed, einv, einx, elat);
        k          = 1;
        busy_ready = 1'b0;
        while (!out_valid && k < 200) begin
            busy_ready |= in_ready;
            @(negedge clk);
            k++;
        end
        check_val("latency", 32'(k), 32'(elat));
        check_val("data", out_data, ed);
        check_val("invalid", 32'(out_invalid), 32'(einv));
        check_val("inexact", 32'(out_inexact), 32'(einx));
        check_val("busy_in_ready", 32'(busy_ready | in_ready), 32'd0);
        d0     = out_data;
        stable = 1'b1;
        if (early) begin
            in_valid = 1'b1;
            in_data  = next_x;
        end
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            stable &= out_valid && !in_ready && (out_data == d0) &&
                      (out_invalid == einv) && (out_inexact == einx);
        end
        if (hold > 0) check_val("hold_stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check_val("post_hs_valid", 32'(out_valid), 32'd0);
        check_val("post_hs_ready", 32'(in_ready), 32'd1);
        $display("txn in=%h out=%h inv=%0d inx=%0d lat=%0d hold=%0d", x, d0, einv, einx, k, hold);
    endtask

    logic [31:0] dir_vec [0:10];
    logic [31:0] x;
    logic        seen;

    initial begin
        dir_vec[0]  = 32'hC020_0000;
        dir_vec[1]  = 32'h4E80_0001;
        dir_vec[2]  = 32'h4F00_0000;
        dir_vec[3]  = 32'hCF00_0000;
        dir_vec[4]  = 32'h7F80_0000;
        dir_vec[5]  = 32'hFF80_0000;
        dir_vec[6]  = 32'h7FC0_0000;
        dir_vec[7]  = 32'h3F40_0000;
        dir_vec[8]  = 32'h0000_0001;
        dir_vec[9]  = 32'h8000_0000;
        dir_vec[10] = 32'h3F80_0000;

        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 32'(in_ready), 32'd0);
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_out_data", out_data, 32'd0);
        check_val("rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1.0 with backpressure, second operand presented early
        send(32'h3F80_0000);
        collect(32'h3F80_0000, 5, 1'b1, 32'h4040_0000);
        send(32'h4040_0000);
        collect(32'h4040_0000, 0, 1'b0, 32'h0);

        for (int i = 0; i < 11; i++) begin
            send(dir_vec[i]);
            collect(dir_vec[i], 0, 1'b0, 32'h0);
        end

        // Reset in the middle of a shift discards the operation
        send(32'h3F80_0000);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_val("midrst_out_valid", 32'(out_valid), 32'd0);
        check_val("midrst_out_data", out_data, 32'd0);
        check_val("midrst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
        check_val("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check_val("postrst_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            seen |= out_valid;
        end
        check_val("stale_result", 32'(seen), 32'd0);
        send(32'h4040_0000);
        collect(32'h4040_0000, 0, 1'b0, 32'h0);

        for (int i = 0; i < 40; i++) begin
            int r;
            r = $urandom_range(0, 9);
            x[31] = 1'($urandom);
            if (r == 0)      x[30:23] = 8'd0;
            else if (r == 1) x[30:23] = 8'd255;
            else             x[30:23] = 8'($urandom_range(110, 165));
            x[22:0] = ($urandom_range(0, 5) == 0) ? 23'd0 : 23'($urandom);
            send(x);
            collect(x, $urandom_range(0, 2), 1'b0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
